bcd_calc_core: RTL
==================

// Module: bcd_calc_core
// PURPOSE
//  Parametrised digit-serial BCD calculator core; successor of the fixed 4-digit push/save/add chain.
//  Collects two N_DIGITS decimal operands from a keypad-style digit stream, then adds them one
//  digit per cycle. Supports chained accumulation and flags overflow.
//  Sits between the debounced keypad front-end and the 7-segment display driver.
// PARAMETERS
//  N_DIGITS  4  BCD digits per operand/result; legal range 1..8.
// PORTS
//  clk        in   1           single clock; all logic on posedge.
//  rst        in   1           synchronous, active-low reset, sampled on posedge clk.
//  push       in   1           1-cycle strobe: enter digit on entrada.
//  guardar    in   1           1-cycle strobe: store operand / start compute / chain result.
//  entrada    in   4           digit value; only 0..9 valid.
//  op_sub     in   1           1 = subtract; sampled with the guardar that starts compute.
//  display    out  4*N_DIGITS  operand being entered, or resultado in DONE.
//  resultado  out  4*N_DIGITS  BCD result; held until the next operation.
//  busy       out  1           high in ADD/FIX states.
//  done       out  1           1-cycle pulse when resultado becomes valid.
//  overflow   out  1           carry out of the MSD on the last add; held until the next compute.
//  neg        out  1           result negative (SUBTRACT_EN only); held like overflow.
//  err        out  1           1-cycle pulse: push with entrada>9.
// BEHAVIOUR
//  Reset (rst==0 at posedge): every register and output is 0; state ENTER_A; digit count 0.
//  States: ENTER_A, ENTER_B, ADD, FIX, DONE.
//  Digit entry, in ENTER_A/ENTER_B:
//   - push with valid digit: numero <= {numero[N-2:0], entrada}; count++.
//   - When count==N_DIGITS: push is ignored and numero is unchanged.
//   - push with entrada>9: err=1 next cycle; numero and count unchanged.
//   - push and guardar in the same cycle: guardar wins; the push is dropped (no err).
//  ENTER_A + guardar: numero_sv <= numero; numero <= 0; count <= 0; go to ENTER_B.
//  ENTER_B + guardar: latch op_sub; idx <= 0; carry <= op_sub; go to ADD.
//  ADD: one digit per cycle, LSD first, for N_DIGITS cycles.
//   - add:      digit = numero_sv[idx] + numero[idx] + carry, decimal-corrected (>9 -> -10, carry 1).
//   - subtract: B digit replaced by its nine's complement (9 - d); carry-in 1.
//   - Last digit, add: overflow <= carry_out; resultado wraps modulo 10^N.
//  FIX (SUBTRACT_EN only): entered after the last subtract digit when carry_out==0.
//   - Ten's-complements resultado in N_DIGITS cycles; neg <= 1.
//   - Subtract never sets overflow.
//  Latency (guardar at cycle t):
//   - done at t+N_DIGITS+1.
//   - Negative subtract: done at t+2*N_DIGITS+1.
//  DONE:
//   - guardar: numero_sv <= resultado; go to ENTER_B (chained accumulation).
//   - push (valid digit): clears all operands; numero <= digit; count <= 1; go to ENTER_A.
//  In ADD/FIX: push and guardar are ignored; err is never raised.
//  Reset mid-ADD/FIX: abort; outputs 0 next cycle; no done pulse.
// CONFIGURATION
//  SUBTRACT_EN defined: op_sub is honoured; FIX state and neg are implemented.
//  SUBTRACT_EN undefined: op_sub is ignored (always add); neg tied 0; FIX state absent.
// STRUCTURE
//  Package bcd_calc_pkg:
//   - DIGIT_W=4; typedef bcd_t = logic[3:0].
//   - state enum calc_state_e.
//   - function is_bcd().
//  Sub-module bcd_digit_adder: combinational a, b, cin, sub -> sum, cout.
//  Core holds FSM, digit counter, idx counter and operand registers.
// TESTING (N_DIGITS=4)
//  1. push 1,2,3,4; guardar; push 5,6,7,8; guardar
//     -> busy 4 cycles; done at t+5; resultado=0x6912; overflow=0.
//  2. 9999 + 0001 -> resultado=0x0000; overflow=1.
//  3. push 1..5 -> display=0x1234 (5th push ignored); push 0xA -> err pulse, display unchanged.
//  4. After test 1: guardar; push 8,8; guardar -> resultado=0x7000 (chained).
//  5. rst=0 during 2nd ADD cycle -> next cycle busy=0, resultado=0, state ENTER_A; done never pulses.
//  6. [SUBTRACT_EN] 0012 - 0045 -> resultado=0x0033; neg=1; done at t+9.
//     0045 - 0012 -> 0x0033; neg=0; done at t+5.

Source files
------------

// File: rtl/bcd_calc_pkg.sv
// Shared types for the digit-serial BCD calculator.
// SUBTRACT_EN adds the FIX state used to ten's-complement negative differences.
package bcd_calc_pkg;

   localparam int DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] bcd_t;

   typedef enum logic [2:0] {
      ENTER_A,
      ENTER_B,
      ADD,
`ifdef SUBTRACT_EN
      FIX,
`endif
      DONE
   } calc_state_e;

   function automatic logic is_bcd(input bcd_t d);
      return (d <= 4'd9);
   endfunction

endpackage

// File: rtl/bcd_calc_if.sv
// Keypad-side and display-side signals of the BCD calculator core.
// master = keypad/display controller, slave = calculator core.
interface bcd_calc_if #(
   parameter int N_DIGITS = 4
);
   import bcd_calc_pkg::*;

   logic                         push;
   logic                         guardar;
   bcd_t                         entrada;
   logic                         op_sub;
   logic [DIGIT_W*N_DIGITS-1:0]  display;
   logic [DIGIT_W*N_DIGITS-1:0]  resultado;
   logic                         busy;
   logic                         done;
   logic                         overflow;
   logic                         neg;
   logic                         err;

   modport master (
      output push, guardar, entrada, op_sub,
      input  display, resultado, busy, done, overflow, neg, err
   );

   modport slave (
      input  push, guardar, entrada, op_sub,
      output display, resultado, busy, done, overflow, neg, err
   );

endinterface

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder; sub selects the nine's complement of b.
module bcd_digit_adder
   import bcd_calc_pkg::*;
(
   input  bcd_t a,
   input  bcd_t b,
   input  logic cin,
   input  logic sub,
   output bcd_t sum,
   output logic cout
);

   bcd_t       b_eff;
   logic [4:0] raw;

   always_comb begin
      b_eff = sub ? bcd_t'(4'd9 - b) : b;
      raw   = {1'b0, a} + {1'b0, b_eff} + {4'd0, cin};
      if (raw > 5'd9) begin
         sum  = bcd_t'(raw - 5'd10);
         cout = 1'b1;
      end else begin
         sum  = raw[3:0];
         cout = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_calc_core.sv
// Digit-serial BCD calculator: two keypad operands, one digit added per cycle.
// Define SUBTRACT_EN to honour op_sub (FIX state and neg flag).
module bcd_calc_core
   import bcd_calc_pkg::*;
#(
   parameter int N_DIGITS = 4
) (
   input  logic       clk,
   input  logic       rst,
   bcd_calc_if.slave  bus
);

   localparam int W     = DIGIT_W * N_DIGITS;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int CNT_W = $clog2(N_DIGITS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_DIGITS);

   calc_state_e           state;
   bcd_t [N_DIGITS-1:0]   numero;
   bcd_t [N_DIGITS-1:0]   numero_sv;
   bcd_t [N_DIGITS-1:0]   res;
   logic [W-1:0]          numero_shift;
   logic [CNT_W-1:0]      count;
   logic [IDX_W-1:0]      idx;
   logic                  carry;
   logic                  sub_q;
   logic                  done_q;
   logic                  err_q;
   logic                  ovf_q;

   bcd_t                  add_a;
   bcd_t                  add_b;
   bcd_t                  add_sum;
   logic                  add_sub;
   logic                  add_cout;

   // Truncating the concatenation drops the MSD and stays legal for N_DIGITS == 1.
   assign numero_shift = W'({numero, bus.entrada});

   always_comb begin
      add_a   = numero_sv[idx];
      add_b   = numero[idx];
      add_sub = sub_q;
`ifdef SUBTRACT_EN
      // FIX computes 0 - res digit by digit, reusing the same adder.
      if (state == FIX) begin
         add_a   = '0;
         add_b   = res[idx];
         add_sub = 1'b1;
      end
`endif
   end

   bcd_digit_adder u_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (carry),
      .sub  (add_sub),
      .sum  (add_sum),
      .cout (add_cout)
   );

`ifdef SUBTRACT_EN
   logic neg_q;
   assign bus.neg = neg_q;
`else
   logic unused_op_sub;
   assign unused_op_sub = bus.op_sub;
   assign sub_q         = 1'b0;
   assign bus.neg       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ENTER_A;
         numero    <= '0;
         numero_sv <= '0;
         res       <= '0;
         count     <= '0;
         idx       <= '0;
         carry     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
`ifdef SUBTRACT_EN
         sub_q     <= 1'b0;
         neg_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            ENTER_A, ENTER_B: begin
               if (bus.guardar) begin
                  if (state == ENTER_A) begin
                     numero_sv <= numero;
                     numero    <= '0;
                     count     <= '0;
                     state     <= ENTER_B;
                  end else begin
                     idx   <= '0;
                     ovf_q <= 1'b0;
`ifdef SUBTRACT_EN
                     sub_q <= bus.op_sub;
                     carry <= bus.op_sub;
                     neg_q <= 1'b0;
`else
                     carry <= 1'b0;
`endif
                     state <= ADD;
                  end
               end else if (bus.push) begin
                  if (!is_bcd(bus.entrada)) begin
                     err_q <= 1'b1;
                  end else if (count != FULL_CNT) begin
                     numero <= numero_shift;
                     count  <= count + 1'b1;
                  end
               end
            end

            ADD: begin
               res[idx] <= add_sum;
               carry    <= add_cout;
               idx      <= idx + 1'b1;
               if (idx == LAST_IDX) begin
`ifdef SUBTRACT_EN
                  // No end-around carry on a subtract means the difference is negative.
                  if (sub_q && !add_cout) begin
                     idx   <= '0;
                     carry <= 1'b1;
                     state <= FIX;
                  end else begin
                     ovf_q  <= add_cout & ~sub_q;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end
`else
                  ovf_q  <= add_cout;
                  done_q <= 1'b1;
                  state  <= DONE;
`endif
               end
            end

`ifdef SUBTRACT_EN
            FIX: begin
               res[idx] <= add_sum;
               carry    <= add_cout;
               idx      <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  neg_q  <= 1'b1;
                  done_q <= 1'b1;
                  state  <= DONE;
               end
            end
`endif

            DONE: begin
               if (bus.guardar) begin
                  numero_sv <= res;
                  numero    <= '0;
                  count     <= '0;
                  state     <= ENTER_B;
               end else if (bus.push) begin
                  if (!is_bcd(bus.entrada)) begin
                     err_q <= 1'b1;
                  end else begin
                     numero_sv <= '0;
                     numero    <= W'(bus.entrada);
                     count     <= CNT_W'(1);
                     state     <= ENTER_A;
                  end
               end
            end

            default: state <= ENTER_A;
         endcase
      end
   end

   assign bus.display   = (state == DONE) ? res : numero;
   assign bus.resultado = res;
`ifdef SUBTRACT_EN
   assign bus.busy      = (state == ADD) || (state == FIX);
`else
   assign bus.busy      = (state == ADD);
`endif
   assign bus.done      = done_q;
   assign bus.overflow  = ovf_q;
   assign bus.err       = err_q;

endmodule
